// File: rtl/tow_pkg.sv
// Shared types and helpers for the Tug-of-War LED bar driver.
package tow_pkg;

    typedef enum logic [1:0] {
        LAMP = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE  = 2'b00,
        WIN_LEFT  = 2'b01,
        WIN_RIGHT = 2'b10
    } winner_t;

    localparam int MAX_LEDS = 32;

    // Positions beyond the widest supported bar yield an all-zero pattern.
    function automatic logic [MAX_LEDS-1:0] onehot(input logic [7:0] p);
        logic [MAX_LEDS-1:0] r;
        r = '0;
        if (int'(p) < MAX_LEDS) begin
            r[p[4:0]] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tow_tick_counter.sv
// Up-counter with synchronous clear; wraps to zero after reaching a runtime terminal value.
module tow_tick_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    assign tc = (cnt == last);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_bar_driver.sv
// LED bar driver: lamp test after reset, one-hot rope position in play, blinking end LED after a win.
//
//   state | meaning
//   LAMP  | all LEDs lit for LAMP_CYCLES cycles after reset; inputs ignored
//   PLAY  | one-hot rope position, ready high, waiting for a win
//   WIN   | winner's end LED blinks with BLINK_DIV half-period until reset
module led_bar_driver
    import tow_pkg::*;
#(
    parameter int NUM_LEDS    = 9,
    parameter int LAMP_CYCLES = 50_000_000,
    parameter int BLINK_DIV   = 12_500_000,
    parameter int POS_W       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [POS_W-1:0]    pos,
    input  logic                pos_valid,
    input  logic                win_l,
    input  logic                win_r,
    output logic [NUM_LEDS-1:0] leds,
    output logic                ready,
    output logic [1:0]          winner
);

    localparam int CNT_MAX = (LAMP_CYCLES > BLINK_DIV) ? LAMP_CYCLES : BLINK_DIV;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int CENTRE  = NUM_LEDS / 2;
    localparam logic [POS_W:0] NUM_LEDS_W = (POS_W+1)'(NUM_LEDS);

    localparam logic [NUM_LEDS-1:0] MASK_CENTRE = NUM_LEDS'(onehot(8'(CENTRE)));
    localparam logic [NUM_LEDS-1:0] MASK_LEFT   = NUM_LEDS'(onehot(8'd0));
    localparam logic [NUM_LEDS-1:0] MASK_RIGHT  = NUM_LEDS'(onehot(8'(NUM_LEDS-1)));

    state_t              state, state_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic                ready_q, ready_d;
    winner_t             winner_q, winner_d;
    logic                phase, phase_d;
    logic                armed, armed_d;
    logic [CNT_W-1:0]    cnt, cnt_last;
    logic                cnt_tc, cnt_clr, cnt_en;

    // The lamp timer starts on the first lit cycle so the bar shows exactly LAMP_CYCLES cycles of all-ones.
    assign cnt_last = (state == LAMP) ? CNT_W'(LAMP_CYCLES - 1) : CNT_W'(BLINK_DIV - 1);
    assign cnt_clr  = (state_d != state);
    assign cnt_en   = ((state == LAMP) && armed) || (state == WIN);

    tow_tick_counter #(.WIDTH(CNT_W)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .last (cnt_last),
        .cnt  (cnt),
        .tc   (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LAMP;
            leds_q   <= '0;
            ready_q  <= 1'b0;
            winner_q <= WIN_NONE;
            phase    <= 1'b0;
            armed    <= 1'b0;
        end else begin
            state    <= state_d;
            leds_q   <= leds_d;
            ready_q  <= ready_d;
            winner_q <= winner_d;
            phase    <= phase_d;
            armed    <= armed_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            LAMP:    if (armed && cnt_tc) state_d = PLAY;
            PLAY:    if (win_l || win_r)  state_d = WIN;
            WIN:     state_d = WIN;
            default: state_d = LAMP;
        endcase
    end

    always_comb begin
        leds_d   = leds_q;
        ready_d  = ready_q;
        winner_d = winner_q;
        phase_d  = phase;
        armed_d  = armed;
        case (state)
            LAMP: begin
                armed_d = 1'b1;
                leds_d  = '1;
                if (state_d == PLAY) begin
                    leds_d  = MASK_CENTRE;
                    ready_d = 1'b1;
                end
            end
            PLAY: begin
                ready_d = 1'b1;
                // A win takes precedence; a simultaneous position update is dropped.
                if (win_l || win_r) begin
                    ready_d  = 1'b0;
                    phase_d  = 1'b1;
                    winner_d = win_l ? WIN_LEFT : WIN_RIGHT;
                    leds_d   = win_l ? MASK_LEFT : MASK_RIGHT;
                end else if (pos_valid && ({1'b0, pos} < NUM_LEDS_W)) begin
                    leds_d = NUM_LEDS'(onehot(8'(pos)));
                end
            end
            WIN: begin
                ready_d = 1'b0;
                if (cnt_tc) begin
                    phase_d = ~phase;
                    if (phase) leds_d = '0;
                    else       leds_d = (winner_q == WIN_LEFT) ? MASK_LEFT : MASK_RIGHT;
                end
            end
            default: begin
                leds_d  = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    assign leds   = leds_q;
    assign ready  = ready_q;
    assign winner = winner_q;

endmodule

// File: tb/tb_led_bar_driver.sv
// Scoreboard bench for led_bar_driver with a short lamp test and blink period.
module tb_led_bar_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] pos = '0;
    logic       pos_valid = 1'b0;
    logic       win_l = 1'b0;
    logic       win_r = 1'b0;
    logic [8:0] leds;
    logic       ready;
    logic [1:0] winner;

    typedef struct {
        logic [8:0] leds;
        logic       ready;
        logic [1:0] winner;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    led_bar_driver #(
        .NUM_LEDS    (9),
        .LAMP_CYCLES (4),
        .BLINK_DIV   (3),
        .POS_W       (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pos       (pos),
        .pos_valid (pos_valid),
        .win_l     (win_l),
        .win_r     (win_r),
        .leds      (leds),
        .ready     (ready),
        .winner    (winner)
    );

    always #5 clk = ~clk;

    // Monitor: every posedge the DUT presents new registered outputs; check them 1 time unit later.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (leds !== e.leds) begin
                n_fails++;
                $display("FAIL %s leds: got %h want %h", e.tag, leds, e.leds);
            end
            n_checks++;
            if (ready !== e.ready) begin
                n_fails++;
                $display("FAIL %s ready: got %b want %b", e.tag, ready, e.ready);
            end
            n_checks++;
            if (winner !== e.winner) begin
                n_fails++;
                $display("FAIL %s winner: got %b want %b", e.tag, winner, e.winner);
            end
        end
    end

    task automatic step(input logic r, input logic pv, input logic [3:0] p,
                        input logic wl, input logic wr,
                        input logic [8:0] el, input logic er, input logic [1:0] ew,
                        input string tag);
        exp_t e;
        @(negedge clk);
        rst       = r;
        pos_valid = pv;
        pos       = p;
        win_l     = wl;
        win_r     = wr;
        e.leds = el; e.ready = er; e.winner = ew; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic idle(input logic [8:0] el, input logic er, input logic [1:0] ew, input string tag);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, el, er, ew, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset, lamp test for exactly 4 cycles, then centre LED.
        step(1, 0, 0, 0, 0, 9'h000, 0, 2'b00, "reset0");
        step(1, 0, 0, 0, 0, 9'h000, 0, 2'b00, "reset1");
        for (int i = 0; i < 4; i++) idle(9'h1FF, 0, 2'b00, "lamp");
        idle(9'h010, 1, 2'b00, "play_entry");

        // Position updates, including an out-of-range index.
        step(0, 1, 4'd0,  0, 0, 9'h001, 1, 2'b00, "pos0");
        idle(9'h001, 1, 2'b00, "hold0");
        step(0, 1, 4'd8,  0, 0, 9'h100, 1, 2'b00, "pos8");
        step(0, 1, 4'd12, 0, 0, 9'h100, 1, 2'b00, "pos12");
        step(0, 1, 4'd9,  0, 0, 9'h100, 1, 2'b00, "pos9");
        step(0, 1, 4'd3,  0, 0, 9'h008, 1, 2'b00, "pos3");
        step(0, 1, 4'd8,  0, 0, 9'h100, 1, 2'b00, "pos8b");

        // Right win: blink end LED, later inputs ignored.
        step(0, 0, 0, 0, 1, 9'h100, 0, 2'b10, "winr");
        step(0, 1, 4'd2, 0, 0, 9'h100, 0, 2'b10, "winr_lit");
        step(0, 0, 0, 1, 0, 9'h100, 0, 2'b10, "winr_lit");
        step(0, 1, 4'd4, 0, 0, 9'h000, 0, 2'b10, "winr_dark");
        step(0, 0, 0, 1, 1, 9'h000, 0, 2'b10, "winr_dark");
        idle(9'h000, 0, 2'b10, "winr_dark");
        for (int i = 0; i < 3; i++) idle(9'h100, 0, 2'b10, "winr_lit2");

        // Reset while lit; lamp test restarts and a win during LAMP is ignored.
        step(1, 0, 0, 0, 0, 9'h000, 0, 2'b00, "midwin_rst");
        for (int i = 0; i < 4; i++) step(0, 1, 4'd1, 1, 0, 9'h1FF, 0, 2'b00, "lamp_winl");
        idle(9'h010, 1, 2'b00, "play_after_lamp");

        // Simultaneous win_l, win_r and pos update: left wins, pos dropped.
        step(0, 1, 4'd2, 1, 1, 9'h001, 0, 2'b01, "both_win");
        idle(9'h001, 0, 2'b01, "winl_lit");
        idle(9'h001, 0, 2'b01, "winl_lit");
        for (int i = 0; i < 3; i++) idle(9'h000, 0, 2'b01, "winl_dark");
        idle(9'h001, 0, 2'b01, "winl_relit");

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/led_bar_driver.md
Name: led_bar_driver

Overview:
- Output-side counterpart to the button input synchronizer in the Tug-of-War game: drives the LED bar showing rope position, in the clock domain.
- Takes the game core's position index and winner flags. Produces registered, glitch-free LED outputs.
- Sequence: lamp test after reset, one-hot position during play, flashing winner end-LED after a win.

Parameters:
- NUM_LEDS, 9, number of LEDs in the bar; centre index = NUM_LEDS/2 = 4.
- LAMP_CYCLES, 50_000_000, cycles all LEDs stay lit after reset (1 s at 50 MHz).
- BLINK_DIV, 12_500_000, cycles per blink half-period in the win state.
- POS_W, 4, width of the position index; must satisfy 2^POS_W >= NUM_LEDS.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- pos  in  POS_W  rope position index, 0 = far left, NUM_LEDS-1 = far right.
- pos_valid  in  1  single-cycle strobe; pos is sampled when high.
- win_l  in  1  left player has won (level or pulse).
- win_r  in  1  right player has won (level or pulse).
- leds  out  NUM_LEDS  LED bar; bit i drives LED i; registered.
- ready  out  1  high only in PLAY state; registered.
- winner  out  2  00 none, 01 left, 10 right; registered, latched until rst.

Behaviour:
- Reset (rst high at posedge, overrides everything):
  - leds=0, ready=0, winner=00, state=LAMP, cycle counter=0, blink phase=0.
- Output timing: all outputs are registered and change one clock after the causing input or state event.
- State LAMP:
  - leds=all ones from the first cycle after rst deasserts.
  - Counter increments each cycle. When it reaches LAMP_CYCLES-1: next state PLAY, leds=one-hot(centre), counter cleared.
  - LAMP_CYCLES=4 means exactly 4 cycles of all-ones.
  - pos_valid, win_l and win_r are ignored in LAMP; wins are not queued.
- State PLAY:
  - ready=1.
  - pos_valid with pos < NUM_LEDS: leds=one-hot(pos) next cycle.
  - pos_valid with pos >= NUM_LEDS: ignored; leds hold.
  - Without pos_valid: leds hold.
  - win_l or win_r high: next state WIN, ready=0, counter cleared, phase=1. Checked before pos_valid in the same cycle; that pos update is dropped.
  - winner=01 for win_l, 10 for win_r.
  - win_l and win_r in the same cycle: left has priority, winner=01.
- State WIN:
  - leds = phase ? mask : 0.
  - mask = bit 0 only for a left win; bit NUM_LEDS-1 only for a right win.
  - Counter counts 0..BLINK_DIV-1, then wraps and toggles phase.
  - First lit interval lasts BLINK_DIV cycles, then BLINK_DIV dark cycles, repeating.
  - All inputs are ignored. WIN is exited only by rst.
- Counter:
  - Width is clog2 of max(LAMP_CYCLES, BLINK_DIV). Shared between LAMP and WIN.
  - Cleared on every state change; never overflows.
- No combinational path from any input to any output.

Decomposition:
- Package tow_pkg:
  - state enum {LAMP, PLAY, WIN}.
  - winner encodings WIN_NONE, WIN_LEFT, WIN_RIGHT.
  - function onehot(pos).
- One sub-module, tow_tick_counter: a parameterised cycle counter with clear input and terminal-count output, used for both the lamp timeout and the blink period.
- The FSM and output registers stay in led_bar_driver.

Test Plan (NUM_LEDS=9, LAMP_CYCLES=4, BLINK_DIV=3):
- rst high 2 cycles, then low → leds=0x000 during reset; 0x1FF for exactly 4 cycles; then 0x010 with ready=1.
- In PLAY, pos_valid with pos=0, then 8, then 12 (one strobe each) → leds 0x001, then 0x100, then holds 0x100; ready stays 1.
- win_r pulse 1 cycle → next cycle ready=0, winner=10, leds=0x100 for 3 cycles, 0x000 for 3, 0x100 for 3; later pos_valid and win_l have no effect.
- win_l, win_r and pos_valid (pos=2) all high in the same PLAY cycle → winner=01, leds=0x001 for 3 cycles then 0x000; the pos update is dropped.
- win_l asserted during LAMP → ignored; PLAY is entered normally with leds=0x010 and winner=00.
- rst asserted mid-WIN while in a lit phase → next cycle leds=0, winner=00, ready=0; the lamp test restarts from 0x1FF.
